// File: rtl/data_types_pkg.sv
// Shared types for the UART transmit path.
//   state_t     : states of the serial transmitter (IDLE/START/DATA/STOP).
//   arb_state_t : states of the transmit arbiter that feeds it.
//   WORD_W      : width of one transmit word (8 data bits + optional 9th bit).
package data_types_pkg;

  localparam int WORD_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_PICK    = 2'd1,
    ARB_PRESENT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_owner : index granted most recently; search starts one above it
//   lock       : per-requester lock; lock[last_owner] & req[last_owner]
//                keeps the previous owner regardless of the pointer
//   valid      : at least one request present
//   win        : selected requester index (only meaningful when valid)
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  input  logic [N_REQ-1:0] lock,
  output logic             valid,
  output logic [IDX_W-1:0] win
);

  // cand[k] = (last_owner + 1 + k) mod N_REQ, i.e. the k-th requester in
  // search order. cand[N_REQ-1] is last_owner itself, so a lone request
  // from the previous owner is still served.
  logic [IDX_W-1:0] cand [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      // Both operands are below N_REQ+1, so one conditional subtract wraps.
      assign sum = {1'b0, last_owner} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ)) ?
                        IDX_W'(sum - (IDX_W+1)'(N_REQ)) : IDX_W'(sum);
    end
  endgenerate

  assign valid = |req;

  always_comb begin
    win = last_owner;
    // Walk backwards so the earliest candidate in search order wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) win = cand[k];
    end
    if (lock[last_owner] && req[last_owner]) win = last_owner;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters.
//   clk, rst           : system clock, synchronous active-high reset
//   req/req_data       : per-requester pending flag and 9-bit word
//   req_lock           : requester keeps the transmitter for its next word
//   gnt                : one-cycle one-hot pulse when the word is accepted
//   owner              : requester currently presented / last accepted
//   busy               : arbiter active or transmitter not idle
//   tx_data/tx_enable  : word and request towards the transmitter
//   tx_idle/tx_finish  : transmitter in IDLE / STOP state
module uart_tx_arbiter
  import data_types_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][WORD_W-1:0]  req_data,
  input  logic [N_REQ-1:0]              req_lock,
  output logic [N_REQ-1:0]              gnt,
  output logic [IDX_W-1:0]              owner,
  output logic                          busy,
  output logic [WORD_W-1:0]             tx_data,
  output logic                          tx_enable,
  input  logic                          tx_idle,
  input  logic                          tx_finish
);

  arb_state_t        state_reg;
  logic [WORD_W-1:0] hold_reg;
  logic [IDX_W-1:0]  owner_reg;
  logic [IDX_W-1:0]  last_owner_reg;
  logic              tx_enable_reg;
  logic              tx_idle_q;
  logic              tx_finish_q;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_win;
  logic              accept;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req),
    .last_owner (last_owner_reg),
    .lock       (req_lock),
    .valid      (pick_valid),
    .win        (pick_win)
  );

  // The transmitter latched our word when it left IDLE, or when it left STOP
  // straight into a new frame. Leaving STOP into IDLE is only a frame end.
  // Gating with rst keeps an aborted presentation from being granted.
  assign accept = (state_reg == ARB_PRESENT) && !rst &&
                  ((tx_idle_q && !tx_idle) ||
                   (tx_finish_q && !tx_finish && !tx_idle));

  // gnt is decoded in the acceptance cycle itself so the requester can
  // retire its word on the same edge the arbiter moves on.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = accept && (owner_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      hold_reg       <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_W'(N_REQ - 1);
      tx_enable_reg  <= 1'b0;
      tx_idle_q      <= 1'b1;
      tx_finish_q    <= 1'b0;
    end else begin
      tx_idle_q   <= tx_idle;
      tx_finish_q <= tx_finish;
      case (state_reg)
        ARB_IDLE: begin
          if (|req) state_reg <= ARB_PICK;
        end
        ARB_PICK: begin
          if (pick_valid) begin
            hold_reg      <= req_data[pick_win];
            owner_reg     <= pick_win;
            tx_enable_reg <= 1'b1;
            state_reg     <= ARB_PRESENT;
          end else begin
            state_reg <= ARB_IDLE;
          end
        end
        ARB_PRESENT: begin
          // Hold the word even if the requester drops req meanwhile.
          if (accept) begin
            tx_enable_reg  <= 1'b0;
            last_owner_reg <= owner_reg;
            state_reg      <= ((req & ~gnt) != '0) ? ARB_PICK : ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign owner     = owner_reg;
  assign tx_data   = hold_reg;
  assign tx_enable = tx_enable_reg;
  assign busy      = (state_reg != ARB_IDLE) || !tx_idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench: arbiter driving a small UART transmitter model with a serial
// receiver; grants and received bytes are checked against queues of
// expected results filled when stimulus is loaded.
module tb_uart_tx_arbiter;
  import data_types_pkg::*;

  localparam int N      = 4;
  localparam int IDX_W  = 2;
  localparam int BR_DIV = 4;
  localparam int FRAME  = 10 * BR_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0][8:0] req_data;
  logic [N-1:0]      req_lock;
  logic [N-1:0]      gnt;
  logic [IDX_W-1:0]  owner;
  logic              busy;
  logic [8:0]        tx_data;
  logic              tx_enable;
  logic              tx_idle;
  logic              tx_finish;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .tx_idle   (tx_idle),
    .tx_finish (tx_finish)
  );

  // ---------------- transmitter model (not affected by rst) ----------------
  state_t     tx_state = IDLE;
  int         tx_cnt   = 0;
  int         tx_bit   = 0;
  logic [7:0] tx_shift = 8'h00;
  logic       line;

  always @(posedge clk) begin
    case (tx_state)
      IDLE: if (tx_enable) begin
        tx_shift <= tx_data[7:0]; tx_cnt <= 0; tx_state <= START;
      end
      START: if (tx_cnt == BR_DIV - 1) begin
        tx_cnt <= 0; tx_bit <= 0; tx_state <= DATA;
      end else tx_cnt <= tx_cnt + 1;
      DATA: if (tx_cnt == BR_DIV - 1) begin
        tx_cnt <= 0;
        if (tx_bit == 7) tx_state <= STOP; else tx_bit <= tx_bit + 1;
      end else tx_cnt <= tx_cnt + 1;
      STOP: if (tx_cnt == BR_DIV - 1) begin
        tx_cnt <= 0;
        if (tx_enable) begin tx_shift <= tx_data[7:0]; tx_state <= START; end
        else tx_state <= IDLE;
      end else tx_cnt <= tx_cnt + 1;
      default: tx_state <= IDLE;
    endcase
  end

  assign tx_idle   = (tx_state == IDLE);
  assign tx_finish = (tx_state == STOP);
  assign line      = (tx_state == START) ? 1'b0 :
                     (tx_state == DATA)  ? tx_shift[tx_bit] : 1'b1;

  // ---------------- scoreboard / requester state ----------------
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         exp_gnt_q[$];
  logic [7:0] exp_byte_q[$];
  int         rx_starts[$];

  logic [8:0] wbuf [N][8];
  int         wcnt [N];
  int         wptr [N];
  int         lock_left [N];
  logic [N-1:0] wd_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i]      = (wptr[i] < wcnt[i]) && !wd_mask[i];
      req_data[i] = (wptr[i] < wcnt[i]) ? wbuf[i][wptr[i]] : 9'h000;
      req_lock[i] = (lock_left[i] > 0);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      wcnt[i] = 0; wptr[i] = 0; lock_left[i] = 0;
    end
    wd_mask = '0;
    drive_reqs();
  endtask

  // Load a word and push the matching expected byte.
  task automatic load_word(input int idx, input logic [8:0] data);
    wbuf[idx][wcnt[idx]] = data;
    wcnt[idx]++;
    exp_byte_q.push_back(data[7:0]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_gnt_q.size() != 0 || exp_byte_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, (n >= max_cyc), 0);
  endtask

  // ---------------- grant monitor ----------------
  initial begin
    int gidx;
    forever begin
      @(negedge clk);
      if (gnt !== '0) begin
        gidx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) gidx = i;
        chk("gnt_onehot", {31'b0, $onehot(gnt)}, 1);
        chk("gnt_owner", {30'b0, owner}, gidx);
        if (exp_gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected actual=%0d required=none", gidx);
        end else begin
          chk("gnt_order", gidx, exp_gnt_q.pop_front());
        end
        $display("grant requester=%0d word=0x%03h cycle=%0d", gidx, tx_data, cyc);
        if (wptr[gidx] < wcnt[gidx]) wptr[gidx]++;
        if (lock_left[gidx] > 0) lock_left[gidx]--;
        drive_reqs();
      end
    end
  end

  // ---------------- serial receiver ----------------
  initial begin
    logic [7:0] rx_byte;
    logic       mid_start;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (line === 1'b0) begin
        rx_starts.push_back(cyc);
        @(negedge clk);
        mid_start = line;
        for (int b = 0; b < 8; b++) begin
          repeat (BR_DIV) @(negedge clk);
          rx_byte[b] = line;
        end
        repeat (BR_DIV) @(negedge clk);
        stop_bit = line;
        $display("frame byte=0x%02h start_cycle=%0d", rx_byte, rx_starts[rx_starts.size()-1]);
        chk("rx_start_bit", {31'b0, mid_start}, 0);
        chk("rx_stop_bit", {31'b0, stop_bit}, 1);
        if (exp_byte_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected actual=0x%02h required=none", rx_byte);
        end else begin
          chk("rx_byte", {24'b0, rx_byte}, {24'b0, exp_byte_q.pop_front()});
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  typedef struct {
    int         idx;
    logic [8:0] data;
    int         exp_gnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int base;

    vecs[0] = '{0, 9'h0A5, 0};
    vecs[1] = '{2, 9'h15A, 2};
    vecs[2] = '{3, 9'h0FF, 3};
    vecs[3] = '{1, 9'h000, 1};

    rst = 1'b1;
    clear_reqs();
    repeat (3) @(negedge clk);
    chk("rst_tx_enable", {31'b0, tx_enable}, 0);
    chk("rst_tx_data", {23'b0, tx_data}, 0);
    chk("rst_gnt", {28'b0, gnt}, 0);
    chk("rst_owner", {30'b0, owner}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single words, one requester at a time; also checks 2-cycle latency.
    for (int v = 0; v < 4; v++) begin
      exp_gnt_q.push_back(vecs[v].exp_gnt);
      load_word(vecs[v].idx, vecs[v].data);
      drive_reqs();
      @(negedge clk);
      chk("lat_enable_c1", {31'b0, tx_enable}, 0);
      @(negedge clk);
      chk("lat_enable_c2", {31'b0, tx_enable}, 1);
      chk("single_busy", {31'b0, busy}, 1);
      wait_drain("single", 200);
      chk("single_line_idle", {31'b0, line}, 1);
      clear_reqs();
    end

    // Fairness: all four pending, requester 0 has two words.
    pulse_reset();
    base = rx_starts.size();
    load_word(0, 9'h010); load_word(1, 9'h011); load_word(2, 9'h012);
    load_word(3, 9'h013); load_word(0, 9'h010);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
    drive_reqs();
    wait_drain("fair", 600);
    chk("fair_frames", rx_starts.size() - base, 5);
    if (rx_starts.size() - base == 5) begin
      for (int k = 1; k < 5; k++)
        chk("fair_b2b_gap", rx_starts[base+k] - rx_starts[base+k-1], FRAME);
    end
    clear_reqs();

    // Lock: requester 0 holds the transmitter for three words.
    pulse_reset();
    load_word(0, 9'h020); load_word(0, 9'h021); load_word(0, 9'h022);
    load_word(1, 9'h030); load_word(0, 9'h023); load_word(1, 9'h031);
    load_word(0, 9'h024); load_word(1, 9'h032);
    // load_word order above matches the expected wire order
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(0); exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(1); exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    lock_left[0] = 3;
    drive_reqs();
    wait_drain("lock", 800);
    clear_reqs();

    // Withdraw: requester 2 drops req while its word is presented.
    pulse_reset();
    load_word(0, 9'h040); load_word(2, 9'h042);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
    drive_reqs();
    n = 0;
    while (!(tx_enable && owner == 2'd2) && n < 200) begin @(negedge clk); n++; end
    chk("wd_present_timeout", (n >= 200), 0);
    wd_mask[2] = 1'b1;
    drive_reqs();
    wait_drain("withdraw", 300);
    clear_reqs();

    // Reset while requester 1's first word is in DATA and its second is presented.
    pulse_reset();
    load_word(1, 9'h051);
    exp_gnt_q.push_back(1);
    drive_reqs();
    wbuf[1][1] = 9'h052; wcnt[1] = 2;   // second word, expected later
    drive_reqs();
    n = 0;
    while (!(tx_state == DATA && tx_enable && owner == 2'd1) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("rst_mid_wait_timeout", (n >= 200), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx_enable", {31'b0, tx_enable}, 0);
    chk("rst_mid_gnt", {28'b0, gnt}, 0);
    chk("rst_mid_owner", {30'b0, owner}, 0);
    chk("rst_mid_busy", {31'b0, busy}, 1);
    rst = 1'b0;
    load_word(0, 9'h050);
    exp_byte_q.push_back(8'h52);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    drive_reqs();
    wait_drain("rst_mid", 400);
    clear_reqs();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
